// File: rtl/life_engine_if.sv
// Edit, step/status and plot-stream signals of the Game of Life engine.
// The master side drives edits/step and consumes plots; the engine is the slave.
interface life_engine_if #(
    parameter int COORD_W = 8
);
    logic               load_valid;
    logic [COORD_W-1:0] load_x;
    logic [COORD_W-1:0] load_y;
    logic               load_alive;
    logic               load_ready;
    logic               step;
    logic               busy;
    logic               done;
    logic [15:0]        generation;
    logic               plot_valid;
    logic               plot_ready;
    logic [COORD_W-1:0] plot_x;
    logic [COORD_W-1:0] plot_y;
    logic [2:0]         plot_colour;

    modport master (
        output load_valid, load_x, load_y, load_alive, step, plot_ready,
        input  load_ready, busy, done, generation, plot_valid, plot_x, plot_y, plot_colour
    );

    modport slave (
        input  load_valid, load_x, load_y, load_alive, step, plot_ready,
        output load_ready, busy, done, generation, plot_valid, plot_x, plot_y, plot_colour
    );
endinterface

// File: rtl/life_engine.sv
// Conway's Game of Life engine: cell edits, one generation per step, changed cells streamed as plots.
// Define LIFE_WRAP_EN for a toroidal grid; otherwise cells outside the grid count as dead.
module life_engine #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 12,
    parameter int COORD_W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    life_engine_if.slave bus
);
    localparam int CELLS = GRID_W * GRID_H;
    localparam int IDX_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CELLS-1:0]   cur_r, cur_s;
    logic [CELLS-1:0]   nxt_r, nxt_s;
    logic [COORD_W-1:0] scan_x_r, scan_x_s;
    logic [COORD_W-1:0] scan_y_r, scan_y_s;
    logic [15:0]        gen_r, gen_s;
    logic               plot_valid_r, plot_valid_s;
    logic [COORD_W-1:0] plot_x_r, plot_x_s;
    logic [COORD_W-1:0] plot_y_r, plot_y_s;
    logic [2:0]         plot_colour_r, plot_colour_s;
    logic               busy_r, busy_s;
    logic               done_r;
    logic               load_ready_r, load_ready_s;

    logic               plot_load_s;
    logic               accept_s;
    logic               load_in_range_s;
    logic [IDX_W-1:0]   load_idx_s;
    logic [IDX_W-1:0]   scan_idx_s;
    logic               cell_cur_s;
    logic               cell_nxt_s;
    logic               changed_s;
    logic               stall_s;
    logic [3:0]         nbr_s;

    function automatic logic cell_at(input logic [CELLS-1:0] g, input int xi, input int yi);
        int   wx;
        int   wy;
        logic v;
        wx = xi;
        wy = yi;
`ifdef LIFE_WRAP_EN
        if (wx < 0) wx = wx + GRID_W;
        else if (wx >= GRID_W) wx = wx - GRID_W;
        else wx = wx;
        if (wy < 0) wy = wy + GRID_H;
        else if (wy >= GRID_H) wy = wy - GRID_H;
        else wy = wy;
        v = g[IDX_W'(wy * GRID_W + wx)];
`else
        if (wx < 0 || wx >= GRID_W || wy < 0 || wy >= GRID_H) v = 1'b0;
        else v = g[IDX_W'(wy * GRID_W + wx)];
`endif
        return v;
    endfunction

    function automatic logic [3:0] count_nbrs(input logic [CELLS-1:0] g, input int cx, input int cy);
        logic [3:0] n;
        n = 4'd0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (dx != 0 || dy != 0) n = n + {3'd0, cell_at(g, cx + dx, cy + dy)};
                else n = n;
            end
        end
        return n;
    endfunction

    // Life rule applied to the cell under the scan pointer
    always_comb begin
        scan_idx_s = IDX_W'(int'(scan_y_r) * GRID_W + int'(scan_x_r));
        load_idx_s = IDX_W'(int'(bus.load_y) * GRID_W + int'(bus.load_x));
        load_in_range_s = (int'(bus.load_x) < GRID_W) && (int'(bus.load_y) < GRID_H);
        cell_cur_s = cur_r[scan_idx_s];
        nbr_s = count_nbrs(cur_r, int'(scan_x_r), int'(scan_y_r));
        if (cell_cur_s) cell_nxt_s = (nbr_s == 4'd2) || (nbr_s == 4'd3);
        else cell_nxt_s = (nbr_s == 4'd3);
        changed_s = (cell_nxt_s != cell_cur_s);
    end

    // Next state, cell writes and plot-slot loading
    always_comb begin
        state_s       = state_r;
        scan_x_s      = scan_x_r;
        scan_y_s      = scan_y_r;
        cur_s         = cur_r;
        nxt_s         = nxt_r;
        gen_s         = gen_r;
        plot_load_s   = 1'b0;
        plot_x_s      = plot_x_r;
        plot_y_s      = plot_y_r;
        plot_colour_s = plot_colour_r;
        accept_s      = bus.load_valid && load_ready_r;
        // A change can only wait for the slot; unchanged cells never stall
        stall_s       = changed_s && plot_valid_r && !bus.plot_ready;

        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (load_in_range_s) begin
                        cur_s[load_idx_s] = bus.load_alive;
                        plot_load_s       = 1'b1;
                        plot_x_s          = bus.load_x;
                        plot_y_s          = bus.load_y;
                        plot_colour_s     = {3{bus.load_alive}};
                    end else begin
                        plot_load_s = 1'b0;
                    end
                end else if (bus.step) begin
                    state_s  = ST_SCAN;
                    scan_x_s = {COORD_W{1'b0}};
                    scan_y_s = {COORD_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (stall_s) begin
                    state_s = ST_SCAN;
                end else begin
                    nxt_s[scan_idx_s] = cell_nxt_s;
                    if (changed_s) begin
                        plot_load_s   = 1'b1;
                        plot_x_s      = scan_x_r;
                        plot_y_s      = scan_y_r;
                        plot_colour_s = {3{cell_nxt_s}};
                    end else begin
                        plot_load_s = 1'b0;
                    end
                    if (scan_x_r == COORD_W'(GRID_W - 1)) begin
                        scan_x_s = {COORD_W{1'b0}};
                        if (scan_y_r == COORD_W'(GRID_H - 1)) state_s = ST_COMMIT;
                        else scan_y_s = scan_y_r + COORD_W'(1'b1);
                    end else begin
                        scan_x_s = scan_x_r + COORD_W'(1'b1);
                    end
                end
            end
            ST_COMMIT: begin
                cur_s   = nxt_r;
                gen_s   = gen_r + 16'd1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (plot_load_s) plot_valid_s = 1'b1;
        else if (bus.plot_ready) plot_valid_s = 1'b0;
        else plot_valid_s = plot_valid_r;

        busy_s       = (state_s != ST_IDLE);
        load_ready_s = (state_s == ST_IDLE) && !plot_valid_s;
    end

    // State and output registers; reset abandons any generation in flight
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cur_r         <= {CELLS{1'b0}};
            nxt_r         <= {CELLS{1'b0}};
            scan_x_r      <= {COORD_W{1'b0}};
            scan_y_r      <= {COORD_W{1'b0}};
            gen_r         <= 16'd0;
            plot_valid_r  <= 1'b0;
            plot_x_r      <= {COORD_W{1'b0}};
            plot_y_r      <= {COORD_W{1'b0}};
            plot_colour_r <= 3'b000;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            load_ready_r  <= 1'b1;
        end else begin
            state_r       <= state_s;
            cur_r         <= cur_s;
            nxt_r         <= nxt_s;
            scan_x_r      <= scan_x_s;
            scan_y_r      <= scan_y_s;
            gen_r         <= gen_s;
            plot_valid_r  <= plot_valid_s;
            plot_x_r      <= plot_x_s;
            plot_y_r      <= plot_y_s;
            plot_colour_r <= plot_colour_s;
            busy_r        <= busy_s;
            done_r        <= (state_r == ST_COMMIT);
            load_ready_r  <= load_ready_s;
        end
    end

    assign bus.load_ready  = load_ready_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.generation  = gen_r;
    assign bus.plot_valid  = plot_valid_r;
    assign bus.plot_x      = plot_x_r;
    assign bus.plot_y      = plot_y_r;
    assign bus.plot_colour = plot_colour_r;
endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed scenarios plus random grids against
// a reference model that evaluates whole generations on a 2-D array.
module tb_life_engine;
    localparam int W  = 16;
    localparam int H  = 12;
    localparam int CW = 8;
    localparam int N  = W * H;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    life_engine_if #(.COORD_W(CW)) bus ();

    life_engine #(.GRID_W(W), .GRID_H(H), .COORD_W(CW)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          checks  = 0;
    int          errors  = 0;
    int          gen_exp = 0;
    bit          grid [H][W];
    logic [18:0] exp_q [$];
    logic [18:0] got_q [$];
    int          lat;

    // Plot handshakes as seen by the consumer
    always @(posedge clock) begin
        if (bus.plot_valid && bus.plot_ready) got_q.push_back({bus.plot_x, bus.plot_y, bus.plot_colour});
    end

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_vec();
        logic [N-1:0] v;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                v[y*W + x] = grid[y][x];
        return v;
    endfunction

    // One generation of the reference model; changed cells queued in row-major order
    task automatic model_step();
        bit nx [H][W];
        int n, xx, yy;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        if (dx != 0 || dy != 0) begin
                            xx = x + dx;
                            yy = y + dy;
`ifdef LIFE_WRAP_EN
                            xx = (xx + W) % W;
                            yy = (yy + H) % H;
                            n += int'(grid[yy][xx]);
`else
                            if (xx >= 0 && xx < W && yy >= 0 && yy < H) n += int'(grid[yy][xx]);
`endif
                        end
                    end
                end
                nx[y][x] = grid[y][x] ? (n == 2 || n == 3) : (n == 3);
                if (nx[y][x] != grid[y][x]) exp_q.push_back({8'(x), 8'(y), {3{nx[y][x]}}});
            end
        end
        grid = nx;
        gen_exp++;
    endtask

    task automatic do_reset();
        bus.load_valid = 1'b0;
        bus.load_x     = 8'd0;
        bus.load_y     = 8'd0;
        bus.load_alive = 1'b0;
        bus.step       = 1'b0;
        bus.plot_ready = 1'b1;
        reset_n        = 1'b0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                grid[y][x] = 1'b0;
        gen_exp = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic load(input int x, input int y, input bit alive);
        int t = 0;
        @(negedge clock);
        while (!bus.load_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!bus.load_ready) check("load_ready_timeout", 1'b0, 1'b1);
        bus.load_valid = 1'b1;
        bus.load_x     = 8'(x);
        bus.load_y     = 8'(y);
        bus.load_alive = alive;
        @(posedge clock);
        #1 bus.load_valid = 1'b0;
        if (x < W && y < H) begin
            grid[y][x] = alive;
            exp_q.push_back({8'(x), 8'(y), {3{alive}}});
        end
    endtask

    task automatic drain();
        int t = 0;
        bus.plot_ready = 1'b1;
        @(negedge clock);
        while (bus.plot_valid && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (bus.plot_valid) check("drain_timeout", 1'b1, 1'b0);
    endtask

    task automatic compare_plots(input string tag);
        int m;
        check({tag, "_count"}, N'(got_q.size()), N'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) check($sformatf("%s_plot%0d", tag, i), N'(got_q[i]), N'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // Step at edge t, then count edges until done; lat is the edge at which done is high
    task automatic run_gen(input bit rnd, input int bp_len, input int extra_step_at, output int lat_o);
        int cyc = 0;
        int bp_left = 0;
        bit first_seen = 1'b0;
        bit seen = 1'b0;
        lat_o = -1;
        @(negedge clock);
        bus.plot_ready = 1'b1;
        bus.step = 1'b1;
        @(posedge clock);
        while (!seen && cyc < 2000) begin
            @(negedge clock);
            bus.step = (cyc == extra_step_at);
            if (bus.done) begin
                seen  = 1'b1;
                lat_o = cyc + 1;
            end
            if (rnd) begin
                bus.plot_ready = 1'($urandom_range(0, 1));
            end else begin
                if (bp_len > 0 && !first_seen && bus.plot_valid) begin
                    first_seen = 1'b1;
                    bp_left    = bp_len;
                end
                bus.plot_ready = (bp_left > 0) ? 1'b0 : 1'b1;
                if (bp_left > 0) bp_left--;
            end
            @(posedge clock);
            cyc++;
        end
        bus.step = 1'b0;
        if (!seen) check("done_timeout", 1'b0, 1'b1);
        #1 check("done_one_cycle", N'(bus.done), N'(1'b0));
    endtask

    task automatic load_blinker();
        load(5, 5, 1'b1);
        load(6, 5, 1'b1);
        load(7, 5, 1'b1);
        drain();
    endtask

    initial begin
        do_reset();
        @(negedge clock);
        check("rst_busy", N'(bus.busy), N'(1'b0));
        check("rst_done", N'(bus.done), N'(1'b0));
        check("rst_gen", N'(bus.generation), N'(16'd0));
        check("rst_plot_valid", N'(bus.plot_valid), N'(1'b0));
        check("rst_load_ready", N'(bus.load_ready), N'(1'b1));
        check("rst_cells", dut.cur_r, {N{1'b0}});

        // Blinker: changes at (6,4), (5,5), (7,5), (6,6)
        load_blinker();
        compare_plots("blinker_load");
        model_step();
        run_gen(1'b0, 0, -1, lat);
        drain();
        compare_plots("blinker_gen");
        check("blinker_latency", N'(lat), N'(N + 2));
        check("blinker_gen_count", N'(bus.generation), N'(gen_exp));
        check("blinker_cells", dut.cur_r, model_vec());

        // Still life block
        do_reset();
        load(2, 2, 1'b1);
        load(3, 2, 1'b1);
        load(2, 3, 1'b1);
        load(3, 3, 1'b1);
        drain();
        compare_plots("block_load");
        model_step();
        run_gen(1'b0, 0, -1, lat);
        drain();
        compare_plots("block_gen");
        check("block_latency", N'(lat), N'(N + 2));
        check("block_cells", dut.cur_r, model_vec());

        // Row 0 edge cells, neighbour addressing depends on the build
        do_reset();
        load(15, 0, 1'b1);
        load(0, 0, 1'b1);
        load(1, 0, 1'b1);
        drain();
        compare_plots("edge_load");
        model_step();
        run_gen(1'b0, 0, -1, lat);
        drain();
        compare_plots("edge_gen");
        check("edge_cells", dut.cur_r, model_vec());

        // Backpressure: ready low for 19 edges after the (6,4) plot appears; cell 85
        // meets a full slot from its evaluation edge to the last low edge, 5 stalls
        do_reset();
        load_blinker();
        compare_plots("bp_load");
        model_step();
        run_gen(1'b0, 19, -1, lat);
        drain();
        compare_plots("bp_gen");
        check("bp_latency", N'(lat), N'(N + 2 + 5));
        check("bp_cells", dut.cur_r, model_vec());

        // Reset in the middle of a scan with a plot held pending
        do_reset();
        load_blinker();
        compare_plots("rst_mid_load");
        @(negedge clock);
        bus.step = 1'b1;
        @(posedge clock);
        #1 bus.step = 1'b0;
        bus.plot_ready = 1'b0;
        repeat (100) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", N'(bus.busy), N'(1'b0));
        check("rst_mid_plot_valid", N'(bus.plot_valid), N'(1'b0));
        check("rst_mid_gen", N'(bus.generation), N'(16'd0));
        check("rst_mid_cur", dut.cur_r, {N{1'b0}});
        check("rst_mid_nxt", dut.nxt_r, {N{1'b0}});
        do_reset();

        // Out-of-range edits are swallowed
        load(16, 0, 1'b1);
        load(0, 12, 1'b1);
        drain();
        compare_plots("oor");
        check("oor_cells", dut.cur_r, {N{1'b0}});

        // Step pulsed while busy must not start another generation
        load_blinker();
        compare_plots("busy_step_load");
        model_step();
        run_gen(1'b0, 0, 50, lat);
        drain();
        compare_plots("busy_step_gen");
        repeat (N + 20) @(negedge clock);
        check("busy_step_gen_count", N'(bus.generation), N'(gen_exp));
        check("busy_step_idle", N'(bus.busy), N'(1'b0));

        // Random grids with random consumer backpressure
        do_reset();
        for (int i = 0; i < 50; i++)
            load($urandom_range(0, W + 1), $urandom_range(0, H + 1), ($urandom_range(0, 3) != 0));
        drain();
        compare_plots("rand_load");
        for (int g = 0; g < 4; g++) begin
            model_step();
            run_gen(1'b1, 0, -1, lat);
            drain();
            compare_plots($sformatf("rand_gen%0d", g));
            check($sformatf("rand_cells%0d", g), dut.cur_r, model_vec());
            check($sformatf("rand_gen_count%0d", g), N'(bus.generation), N'(gen_exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
